// File: rtl/gate_gen_pkg.sv
// Shared types and default constants for the gate generator.
package gate_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GAP     = 2'd1,
    ON_MIN  = 2'd2,
    ON_HOLD = 2'd3
  } gate_state_t;

  localparam int DEF_MIN_CYCLES = 4;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_MAX_CYCLES = 16;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it reads zero.
module cycle_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority over counting; the count parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_generator.sv
// Rebuilds a gate level from note-on/note-off pulses with a guaranteed minimum
// high time, a forced low gap on retrigger, and one-cycle trig/rel edge markers.
// Optional macro GATE_GEN_MAX_LEN_EN adds an auto-release after MAX_CYCLES high.
// Handshake: none; on_pulse/off_pulse are single-cycle strobes sampled every
// posedge, and all outputs are registered with one cycle of latency.
module gate_generator
  import gate_gen_pkg::*;
#(
  parameter int MIN_CYCLES = DEF_MIN_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       on_pulse,
  input  logic       off_pulse,
  output logic       gate,
  output logic       trig,
  output logic       rel,
  output logic [1:0] state_dbg
);

  localparam logic [CNT_W-1:0] MIN_LOAD = CNT_W'(MIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  // Reject parameter sets that would break the minimum-width guarantees.
  if (MIN_CYCLES < 1 || GAP_CYCLES < 1 || MAX_CYCLES <= MIN_CYCLES) begin : g_param_chk
    $error("gate_generator: illegal cycle parameters");
  end

  gate_state_t      state, state_next;
  logic             pend_off, pend_next;
  logic             gate_next, trig_next, rel_next;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             max_expire;

  // Single counter shared by the GAP and ON_MIN phases.
  cycle_down_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (mclk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (!cnt_load),
    .zero     (cnt_zero)
  );

`ifdef GATE_GEN_MAX_LEN_EN
  localparam logic [CNT_W-1:0] MAX_LOAD = CNT_W'(MAX_CYCLES - 1);
  logic max_zero;

  // High-time counter restarts on every rising gate edge, so a retrigger clears it.
  cycle_down_counter #(.CNT_W(CNT_W)) u_max_cnt (
    .clk      (mclk),
    .rst      (rst),
    .load     (trig_next),
    .load_val (MAX_LOAD),
    .en       (gate),
    .zero     (max_zero)
  );

  assign max_expire = gate && max_zero;
`else
  assign max_expire = 1'b0;
`endif

  // Next-state logic; on_pulse always beats off_pulse.
  always_comb begin
    state_next = state;
    pend_next  = pend_off;
    cnt_load   = 1'b0;
    cnt_val    = MIN_LOAD;
    case (state)
      IDLE: begin
        if (on_pulse) begin
          state_next = ON_MIN;
          cnt_load   = 1'b1;
          cnt_val    = MIN_LOAD;
        end
      end
      GAP: begin
        // A repeated on_pulse is absorbed and does not restart the gap.
        if (off_pulse && !on_pulse) begin
          state_next = IDLE;
        end else if (cnt_zero) begin
          state_next = ON_MIN;
          cnt_load   = 1'b1;
          cnt_val    = MIN_LOAD;
        end
      end
      ON_MIN: begin
        if (on_pulse) begin
          state_next = GAP;
          cnt_load   = 1'b1;
          cnt_val    = GAP_LOAD;
          pend_next  = 1'b0;
        end else if (max_expire) begin
          state_next = IDLE;
          pend_next  = 1'b0;
        end else if (cnt_zero) begin
          state_next = (pend_off || off_pulse) ? IDLE : ON_HOLD;
          pend_next  = 1'b0;
        end else if (off_pulse) begin
          pend_next  = 1'b1;
        end
      end
      ON_HOLD: begin
        if (on_pulse) begin
          state_next = GAP;
          cnt_load   = 1'b1;
          cnt_val    = GAP_LOAD;
        end else if (off_pulse || max_expire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    gate_next = (state_next == ON_MIN) || (state_next == ON_HOLD);
    trig_next = gate_next && !gate;
    rel_next  = !gate_next && gate;
  end

  // State and registered outputs; reset drops gate without a rel marker.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state    <= IDLE;
      pend_off <= 1'b0;
      gate     <= 1'b0;
      trig     <= 1'b0;
      rel      <= 1'b0;
    end else begin
      state    <= state_next;
      pend_off <= pend_next;
      gate     <= gate_next;
      trig     <= trig_next;
      rel      <= rel_next;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_gate_generator.sv
// Directed bench for gate_generator with MIN=4, GAP=2, MAX=16.
// Cycle n is the clock period after the n-th posedge following reset release;
// a pulse applied in cycle n shows on the outputs in cycle n+1.
module tb_gate_generator;

  logic       mclk;
  logic       rst;
  logic       on_pulse;
  logic       off_pulse;
  logic       gate;
  logic       trig;
  logic       rel;
  logic [1:0] state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc;

  logic [127:0] g_log, t_log, r_log;

  gate_generator #(
    .MIN_CYCLES (4),
    .GAP_CYCLES (2),
    .MAX_CYCLES (16),
    .CNT_W      (16)
  ) dut (
    .mclk      (mclk),
    .rst       (rst),
    .on_pulse  (on_pulse),
    .off_pulse (off_pulse),
    .gate      (gate),
    .trig      (trig),
    .rel       (rel),
    .state_dbg (state_dbg)
  );

  // Clock
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Bit mask with bits lo..hi set.
  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // One clock of stimulus, then log the outputs for the following cycle.
  task automatic step(input logic on, input logic off, input logic r);
    on_pulse  = on;
    off_pulse = off;
    rst       = r;
    @(posedge mclk);
    #1;
    cyc++;
    g_log[cyc] = gate;
    t_log[cyc] = trig;
    r_log[cyc] = rel;
  endtask

  // Reset, then play a stimulus schedule of len cycles.
  task automatic run(input logic [127:0] on_m, input logic [127:0] off_m,
                     input logic [127:0] rst_m, input int len);
    on_pulse  = 1'b0;
    off_pulse = 1'b0;
    rst       = 1'b1;
    @(posedge mclk);
    #1;
    cyc   = 0;
    g_log = '0;
    t_log = '0;
    r_log = '0;
    for (int i = 0; i < len; i++) step(on_m[cyc], off_m[cyc], rst_m[cyc]);
    on_pulse  = 1'b0;
    off_pulse = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    on_pulse  = 1'b1;
    off_pulse = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    vec_cnt++;
    if ({gate, trig, rel} !== 3'b000) begin
      err_cnt++;
      $display("FAIL reset outputs: got %b want 000", {gate, trig, rel});
    end
    vec_cnt++;
    if (state_dbg !== 2'd0) begin
      err_cnt++;
      $display("FAIL reset state: got %0d want 0", state_dbg);
    end
    on_pulse = 1'b0;
  endtask

  task automatic test_normal;
    logic [127:0] eg, et, er;
    // off at cycle 5 lands in IDLE and must be ignored
    run(rng(10, 10), rng(5, 5) | rng(20, 20), '0, 30);
    eg = rng(11, 20); et = rng(11, 11); er = rng(21, 21);
    for (int c = 1; c <= 30; c++) begin
      vec_cnt++;
      if ({g_log[c], t_log[c], r_log[c]} !== {eg[c], et[c], er[c]}) begin
        err_cnt++;
        $display("FAIL normal cyc %0d: gate/trig/rel got %b want %b", c,
                 {g_log[c], t_log[c], r_log[c]}, {eg[c], et[c], er[c]});
      end
    end
  endtask

  task automatic test_short;
    logic [127:0] eg, et, er;
    run(rng(10, 10), rng(11, 11), '0, 25);
    eg = rng(11, 14); et = rng(11, 11); er = rng(15, 15);
    for (int c = 1; c <= 25; c++) begin
      vec_cnt++;
      if ({g_log[c], t_log[c], r_log[c]} !== {eg[c], et[c], er[c]}) begin
        err_cnt++;
        $display("FAIL short cyc %0d: gate/trig/rel got %b want %b", c,
                 {g_log[c], t_log[c], r_log[c]}, {eg[c], et[c], er[c]});
      end
    end
  endtask

  task automatic test_off_at_min_end;
    logic [127:0] eg, et, er;
    // off arrives on the very cycle the min counter reaches zero
    run(rng(10, 10), rng(14, 14), '0, 25);
    eg = rng(11, 14); et = rng(11, 11); er = rng(15, 15);
    for (int c = 1; c <= 25; c++) begin
      vec_cnt++;
      if ({g_log[c], t_log[c], r_log[c]} !== {eg[c], et[c], er[c]}) begin
        err_cnt++;
        $display("FAIL min_end cyc %0d: gate/trig/rel got %b want %b", c,
                 {g_log[c], t_log[c], r_log[c]}, {eg[c], et[c], er[c]});
      end
    end
  endtask

  task automatic test_retrigger;
    logic [127:0] eg, et, er;
    run(rng(10, 10) | rng(20, 20), '0, '0, 35);
    eg = rng(11, 20) | rng(23, 35); et = rng(11, 11) | rng(23, 23); er = rng(21, 21);
    for (int c = 1; c <= 35; c++) begin
      vec_cnt++;
      if ({g_log[c], t_log[c], r_log[c]} !== {eg[c], et[c], er[c]}) begin
        err_cnt++;
        $display("FAIL retrig cyc %0d: gate/trig/rel got %b want %b", c,
                 {g_log[c], t_log[c], r_log[c]}, {eg[c], et[c], er[c]});
      end
    end
  endtask

  task automatic test_gap_off;
    logic [127:0] eg, et, er;
    // off during the gap cancels the note: no trig afterwards
    run(rng(10, 10) | rng(20, 20), rng(21, 21), '0, 35);
    eg = rng(11, 20); et = rng(11, 11); er = rng(21, 21);
    for (int c = 1; c <= 35; c++) begin
      vec_cnt++;
      if ({g_log[c], t_log[c], r_log[c]} !== {eg[c], et[c], er[c]}) begin
        err_cnt++;
        $display("FAIL gap_off cyc %0d: gate/trig/rel got %b want %b", c,
                 {g_log[c], t_log[c], r_log[c]}, {eg[c], et[c], er[c]});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] eg, et, er;
    // repeated ons inside the gap are absorbed; gap length stays 2
    run(rng(10, 10) | rng(20, 22), '0, '0, 35);
    eg = rng(11, 20) | rng(23, 35); et = rng(11, 11) | rng(23, 23); er = rng(21, 21);
    for (int c = 1; c <= 35; c++) begin
      vec_cnt++;
      if ({g_log[c], t_log[c], r_log[c]} !== {eg[c], et[c], er[c]}) begin
        err_cnt++;
        $display("FAIL b2b cyc %0d: gate/trig/rel got %b want %b", c,
                 {g_log[c], t_log[c], r_log[c]}, {eg[c], et[c], er[c]});
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [127:0] eg, et, er;
    run(rng(10, 10), rng(10, 10) | rng(25, 25), '0, 30);
    eg = rng(11, 25); et = rng(11, 11); er = rng(26, 26);
    for (int c = 1; c <= 30; c++) begin
      vec_cnt++;
      if ({g_log[c], t_log[c], r_log[c]} !== {eg[c], et[c], er[c]}) begin
        err_cnt++;
        $display("FAIL simul cyc %0d: gate/trig/rel got %b want %b", c,
                 {g_log[c], t_log[c], r_log[c]}, {eg[c], et[c], er[c]});
      end
    end
  endtask

  task automatic test_max_len;
    logic [127:0] eg, et, er;
    int len;
`ifdef GATE_GEN_MAX_LEN_EN
    len = 40;
    run(rng(10, 10), rng(30, 30), '0, len);
    eg = rng(11, 26); et = rng(11, 11); er = rng(27, 27);
`else
    len = 100;
    run(rng(10, 10), '0, '0, len);
    eg = rng(11, 100); et = rng(11, 11); er = '0;
`endif
    for (int c = 1; c <= len; c++) begin
      vec_cnt++;
      if ({g_log[c], t_log[c], r_log[c]} !== {eg[c], et[c], er[c]}) begin
        err_cnt++;
        $display("FAIL maxlen cyc %0d: gate/trig/rel got %b want %b", c,
                 {g_log[c], t_log[c], r_log[c]}, {eg[c], et[c], er[c]});
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] eg, et, er;
    run(rng(10, 10) | rng(20, 20), rng(30, 30), rng(15, 15), 35);
    eg = rng(11, 15) | rng(21, 30); et = rng(11, 11) | rng(21, 21); er = rng(31, 31);
    for (int c = 1; c <= 35; c++) begin
      vec_cnt++;
      if ({g_log[c], t_log[c], r_log[c]} !== {eg[c], et[c], er[c]}) begin
        err_cnt++;
        $display("FAIL rst_mid cyc %0d: gate/trig/rel got %b want %b", c,
                 {g_log[c], t_log[c], r_log[c]}, {eg[c], et[c], er[c]});
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    on_pulse  = 1'b0;
    off_pulse = 1'b0;
    cyc       = 0;
    test_reset;
    test_normal;
    test_short;
    test_off_at_min_end;
    test_retrigger;
    test_gap_off;
    test_back_to_back;
    test_simultaneous;
    test_max_len;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
